// File: rtl/gated_mac_sequencer.sv
// gated_mac_sequencer: sequential sum-of-products over six gated 9x8 terms,
// one shared multiplier, ready/valid on operand and result sides.
module gated_mac_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [53:0] a_bus,
  input  logic [47:0] b_bus,
  input  logic [5:0]  gate,
  input  logic [6:0]  offset,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:0] out_data,
  output logic [15:0] mul_count
);

  localparam int unsigned NTERM = 6;
  localparam int unsigned AW    = 9;
  localparam int unsigned BW    = 8;
  localparam int unsigned ACCW  = 17;
  localparam int unsigned CNTW  = 16;
  localparam int unsigned OFFW  = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                 state_q;
  logic [NTERM*AW-1:0]    a_q;
  logic [NTERM*BW-1:0]    b_q;
  logic [NTERM-1:0]       pend_q;
  logic [ACCW-1:0]        acc_q;
  logic                   out_valid_q;
  logic [ACCW-1:0]        out_data_q;
  logic [CNTW-1:0]        mul_cnt_q;

  logic [AW-1:0]          a_sel;
  logic [BW-1:0]          b_sel;
  logic [NTERM-1:0]       sel_oh;
  logic                   found;
  logic [ACCW-1:0]        prod;
  logic [ACCW-1:0]        acc_d;
  logic [NTERM-1:0]       pend_d;
  logic [CNTW-1:0]        mul_cnt_d;
  logic [ACCW-1:0]        offset_ext;

  // Pick the lowest pending term and compute this cycle's accumulation.
  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    sel_oh = '0;
    found  = 1'b0;
    for (int i = 0; i < int'(NTERM); i++) begin
      if (pend_q[i] && !found) begin
        a_sel     = a_q[AW*i +: AW];
        b_sel     = b_q[BW*i +: BW];
        sel_oh[i] = 1'b1;
        found     = 1'b1;
      end
    end
    prod      = ACCW'(a_sel) * ACCW'(b_sel);
    acc_d     = acc_q + prod;
    pend_d    = pend_q & ~sel_oh;
    mul_cnt_d = (mul_cnt_q == {CNTW{1'b1}}) ? mul_cnt_q : mul_cnt_q + CNTW'(1);
  end

  assign offset_ext = ACCW'(offset);

  // Sequencer: accept operands, walk pending terms, hold result until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      pend_q      <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      mul_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q    <= a_bus;
            b_q    <= b_bus;
            acc_q  <= offset_ext;
            pend_q <= ~gate;
            if (gate == {NTERM{1'b1}}) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= offset_ext;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          acc_q     <= acc_d;
          pend_q    <= pend_d;
          mul_cnt_q <= mul_cnt_d;
          if (pend_d == '0) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= acc_d;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Ready is a pure decode of state so reset shows it immediately.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign mul_count = mul_cnt_q;

  // OFFW documents the addend width; the zero-extension above relies on it.
  logic unused_ok;
  assign unused_ok = (OFFW == 7);

endmodule

// File: tb/tb_gated_mac_sequencer.sv
// Directed bench for gated_mac_sequencer with hand-computed expectations.
module tb_gated_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [53:0] a_bus;
  logic [47:0] b_bus;
  logic [5:0]  gate;
  logic [6:0]  offset;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_data;
  logic [15:0] mul_count;

  int tests = 0;
  int fails = 0;
  int exp_mc = 0;

  gated_mac_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .gate      (gate),
    .offset    (offset),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .mul_count (mul_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive all six terms with the same a/b values.
  task automatic set_uniform(input logic [8:0] a, input logic [7:0] b);
    for (int k = 0; k < 6; k++) begin
      a_bus[9*k +: 9] = a;
      b_bus[8*k +: 8] = b;
    end
  endtask

  // Present the operand set and return after the accept edge.
  task automatic accept(input logic [5:0] g, input logic [6:0] off);
    gate     = g;
    offset   = off;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Count cycles until out_valid, bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [5:0] g, input logic [6:0] off,
                        input int exp_data, input int exp_lat, input int n);
    int lat;
    accept(g, off);
    wait_valid(lat);
    exp_mc += n;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, 32'(out_data), 32'(exp_data));
    check({tag, "_mul_count"}, 32'(mul_count), 32'(exp_mc));
    check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    take_result(tag);
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_bus = '0; b_bus = '0; gate = '0; offset = '0;
    #1;
    check("rst_in_ready_async", 32'(in_ready), 32'd1);
    step(); step();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_mul_count", 32'(mul_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // All terms max: 6*130305+127 = 781957 mod 2^17 = 126597.
    set_uniform(9'd511, 8'd255);
    run_op("full", 6'b000000, 7'd127, 126597, 6, 6);

    // All gated: result is the offset after one cycle.
    set_uniform(9'd77, 8'd33);
    run_op("allgated", 6'b111111, 7'd100, 100, 1, 0);

    // Terms 0/2/4 at 3*5, gated terms at max: 7+45 = 52.
    set_uniform(9'd511, 8'd255);
    for (int k = 0; k < 6; k += 2) begin
      a_bus[9*k +: 9] = 9'd3;
      b_bus[8*k +: 8] = 8'd5;
    end
    run_op("alt", 6'b101010, 7'd7, 52, 3, 3);

    // Single highest term: 2*3 = 6.
    set_uniform(9'd400, 8'd200);
    a_bus[45 +: 9] = 9'd2;
    b_bus[40 +: 8] = 8'd3;
    run_op("term5", 6'b011111, 7'd0, 6, 1, 1);

    // Backpressure: result held while a new operand set is offered.
    set_uniform(9'd511, 8'd255);
    for (int k = 0; k < 6; k += 2) begin
      a_bus[9*k +: 9] = 9'd3;
      b_bus[8*k +: 8] = 8'd5;
    end
    accept(6'b101010, 7'd7);
    wait_valid(lat);
    exp_mc += 3;
    check("bp_latency", 32'(lat), 32'd3);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        set_uniform(9'd1, 8'd1);
        gate = 6'b000000; offset = 7'd1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      check("bp_data_stable", 32'(out_data), 32'd52);
      check("bp_valid_held", 32'(out_valid), 32'd1);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("bp_no_capture_mc", 32'(mul_count), 32'(exp_mc));
    take_result("bp");
    check("bp_data_retained", 32'(out_data), 32'd52);
    step();
    check("bp_still_idle", 32'(in_ready), 32'd1);
    check("bp_no_capture_valid", 32'(out_valid), 32'd0);

    // Operand change after accept: a=k+1, b=10 -> 10*21 = 210.
    for (int k = 0; k < 6; k++) begin
      a_bus[9*k +: 9] = 9'(k + 1);
      b_bus[8*k +: 8] = 8'd10;
    end
    accept(6'b000000, 7'd0);
    set_uniform(9'd511, 8'd255);
    gate = 6'b111111; offset = 7'd99;
    wait_valid(lat);
    exp_mc += 6;
    check("chg_latency", 32'(lat), 32'd6);
    check("chg_data", 32'(out_data), 32'd210);
    check("chg_mul_count", 32'(mul_count), 32'(exp_mc));
    take_result("chg");

    // Reset after two of six terms.
    set_uniform(9'd511, 8'd255);
    accept(6'b000000, 7'd127);
    step(); step();
    check("mid_mul_count_pre", 32'(mul_count), 32'(exp_mc + 2));
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_mul_count", 32'(mul_count), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    exp_mc = 0;
    step();
    check("post_rst_idle_valid", 32'(out_valid), 32'd0);
    run_op("post_rst", 6'b000000, 7'd127, 126597, 6, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
